// File: rtl/riscv_mem_responder.sv
// Unified instruction/data memory model with a small MMIO block (TOHOST, CYCLE, SCRATCH) for CPU benches.
// Both read ports register one cycle after the address and forward any same-cycle write.
module riscv_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] pc,
  input  logic [29:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] mem_write_data,
  input  logic        load_en,
  input  logic [29:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] instr,
  output logic [31:0] mem_read_data,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        collision
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] OFF_TOHOST  = 8'h00;
  localparam logic [7:0] OFF_CYCLE   = 8'h01;
  localparam logic [7:0] OFF_SCRATCH = 8'h02;

  logic [31:0] mem [DEPTH];

  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] tohost_q, tohost_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cycle_q, cycle_d;
  logic        halt_q, halt_d;
  logic        coll_q, coll_d;

  logic                  pc_mmio, da_mmio, ld_mmio;
  logic [DEPTH_LOG2-1:0] pc_idx, da_idx, ld_idx, wr_idx;
  logic                  ld_we, cpu_ram_we, cpu_mmio_we, ram_we;
  logic [31:0]           wr_dat;
  logic [31:0]           mmio_rdata;

  assign pc_mmio = &pc[29:8];
  assign da_mmio = &mem_addr[29:8];
  assign ld_mmio = &load_addr[29:8];
  assign pc_idx  = pc[DEPTH_LOG2-1:0];
  assign da_idx  = mem_addr[DEPTH_LOG2-1:0];
  assign ld_idx  = load_addr[DEPTH_LOG2-1:0];

  // Single RAM write port: the loader wins, nothing lands in RAM during reset.
  // Loader addresses in the MMIO window have no RAM target and are dropped.
  assign ld_we       = load_en & ~ld_mmio & ~rst;
  assign cpu_ram_we  = mem_write & ~halt_q & ~da_mmio & ~rst;
  assign cpu_mmio_we = mem_write & ~halt_q & da_mmio;
  assign ram_we      = ld_we | cpu_ram_we;
  assign wr_idx      = ld_we ? ld_idx : da_idx;
  assign wr_dat      = ld_we ? load_data : mem_write_data;

  assign cycle_d = halt_q ? cycle_q : cycle_q + 32'd1;

  always_comb begin
    mmio_rdata = 32'h0;
    case (mem_addr[7:0])
      OFF_TOHOST:  mmio_rdata = (cpu_mmio_we) ? mem_write_data : tohost_q;
      OFF_CYCLE:   mmio_rdata = cycle_q;
      OFF_SCRATCH: mmio_rdata = (cpu_mmio_we) ? mem_write_data : scratch_q;
      default:     mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    instr_d   = mem[pc_idx];
    rdata_d   = mem[da_idx];
    tohost_d  = tohost_q;
    scratch_d = scratch_q;
    halt_d    = halt_q;
    coll_d    = coll_q | (ld_we & cpu_ram_we);

    if (pc_mmio) begin
      instr_d = 32'h0;
    end else if (ram_we && (wr_idx == pc_idx)) begin
      instr_d = wr_dat;
    end

    if (da_mmio) begin
      rdata_d = mmio_rdata;
    end else if (ram_we && (wr_idx == da_idx)) begin
      rdata_d = wr_dat;
    end

    if (cpu_mmio_we && (mem_addr[7:0] == OFF_TOHOST)) begin
      tohost_d = mem_write_data;
      halt_d   = halt_q | (mem_write_data != 32'h0);
    end
    if (cpu_mmio_we && (mem_addr[7:0] == OFF_SCRATCH)) begin
      scratch_d = mem_write_data;
    end
  end

  // RAM is deliberately outside reset so a program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      rdata_q   <= 32'h0;
      tohost_q  <= 32'h0;
      scratch_q <= 32'h0;
      cycle_q   <= 32'h0;
      halt_q    <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      tohost_q  <= tohost_d;
      scratch_q <= scratch_d;
      cycle_q   <= cycle_d;
      halt_q    <= halt_d;
      coll_q    <= coll_d;
    end
  end

  assign instr         = instr_q;
  assign mem_read_data = rdata_q;
  assign tohost        = tohost_q;
  assign halt          = halt_q;
  assign collision     = coll_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder: expectations queued with the stimulus, checked after each edge.
module tb_riscv_mem_responder;

  localparam logic [29:0] A_TOHOST  = 30'h3FFF_FF00;
  localparam logic [29:0] A_CYCLE   = 30'h3FFF_FF01;
  localparam logic [29:0] A_SCRATCH = 30'h3FFF_FF02;
  localparam logic [29:0] A_OFF10   = 30'h3FFF_FF10;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam int K_INSTR = 0;
  localparam int K_RDATA = 1;
  localparam int K_HALT  = 2;
  localparam int K_TOHOST = 3;
  localparam int K_COLL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] pc, mem_addr, load_addr;
  logic        mem_write, load_en;
  logic [31:0] mem_write_data, load_data;
  logic [31:0] instr, mem_read_data, tohost;
  logic        halt, collision;

  int total = 0;
  int bad   = 0;

  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  logic [31:0] mcyc  = 32'h0;
  logic        mhalt = 1'b0;

  riscv_mem_responder dut (
    .clk(clk), .rst(rst), .pc(pc), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .instr(instr), .mem_read_data(mem_read_data),
    .halt(halt), .tohost(tohost), .collision(collision)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  // One clock: update the reference CYCLE/halt model, then drain the scoreboard.
  task automatic cyc();
    logic        nh;
    logic [31:0] nc;
    int          k;
    logic [31:0] e;
    logic [31:0] got;
    string       n;
    nh = mhalt | (!rst && mem_write && !mhalt && mem_addr == A_TOHOST && mem_write_data != 32'h0);
    nc = mhalt ? mcyc : mcyc + 32'd1;
    if (rst) begin
      nh = 1'b0;
      nc = 32'h0;
    end
    @(posedge clk);
    #1;
    mhalt = nh;
    mcyc  = nc;
    while (q_kind.size() > 0) begin
      k = q_kind.pop_front();
      e = q_exp.pop_front();
      n = q_name.pop_front();
      case (k)
        K_INSTR:  got = instr;
        K_RDATA:  got = mem_read_data;
        K_HALT:   got = {31'h0, halt};
        K_TOHOST: got = tohost;
        default:  got = {31'h0, collision};
      endcase
      chk(n, got, e);
    end
  endtask

  task automatic quiet();
    mem_write = 1'b0;
    load_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = '0; mem_addr = '0; mem_write = 1'b0; mem_write_data = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // reset state
    expect_val(K_INSTR, NOP, "rst_instr");
    expect_val(K_RDATA, 32'h0, "rst_rdata");
    expect_val(K_HALT, 32'h0, "rst_halt");
    expect_val(K_TOHOST, 32'h0, "rst_tohost");
    expect_val(K_COLL, 32'h0, "rst_coll");
    cyc();

    // load mem[0], fetch it with same-cycle forwarding
    rst = 1'b0;
    load_en = 1'b1; load_addr = 30'd0; load_data = 32'h0050_0093;
    pc = 30'd0; mem_addr = A_CYCLE;
    expect_val(K_INSTR, 32'h0050_0093, "fetch_fwd");
    expect_val(K_RDATA, mcyc, "cycle_first");
    cyc();

    load_addr = 30'd3; load_data = 32'h3333_3333;
    expect_val(K_INSTR, 32'h0050_0093, "fetch_ram");
    expect_val(K_RDATA, mcyc, "cycle_second");
    cyc();

    // CPU store with same-cycle read on both ports
    quiet();
    mem_write = 1'b1; mem_addr = 30'd5; mem_write_data = 32'hDEAD_BEEF; pc = 30'd5;
    expect_val(K_RDATA, 32'hDEAD_BEEF, "store_fwd_data");
    expect_val(K_INSTR, 32'hDEAD_BEEF, "store_fwd_instr");
    cyc();
    quiet();
    expect_val(K_RDATA, 32'hDEAD_BEEF, "store_ram_data");
    expect_val(K_INSTR, 32'hDEAD_BEEF, "store_ram_instr");
    cyc();

    // loader and CPU MMIO write together: both land, no collision
    load_en = 1'b1; load_addr = 30'd20; load_data = 32'h0000_1234; pc = 30'd20;
    mem_write = 1'b1; mem_addr = A_SCRATCH; mem_write_data = 32'h0000_A5A5;
    expect_val(K_INSTR, 32'h0000_1234, "ld_mmio_instr");
    expect_val(K_RDATA, 32'h0000_A5A5, "scratch_fwd");
    expect_val(K_COLL, 32'h0, "no_coll_mmio");
    cyc();

    // collision: loader wins, CPU store dropped
    quiet();
    load_en = 1'b1; load_addr = 30'd9; load_data = 32'h9999_9999;
    cyc();
    load_addr = 30'd7; load_data = 32'h1111_1111;
    mem_write = 1'b1; mem_addr = 30'd9; mem_write_data = 32'h2222_2222; pc = 30'd7;
    expect_val(K_INSTR, 32'h1111_1111, "coll_ld_fwd");
    expect_val(K_RDATA, 32'h9999_9999, "coll_cpu_nofwd");
    expect_val(K_COLL, 32'h1, "coll_set");
    cyc();
    quiet();
    expect_val(K_INSTR, 32'h1111_1111, "coll_mem7");
    expect_val(K_RDATA, 32'h9999_9999, "coll_mem9");
    expect_val(K_COLL, 32'h1, "coll_sticky");
    cyc();

    // upper address bits alias onto the RAM index
    mem_write = 1'b1; mem_addr = 30'h3FFF_1005; mem_write_data = 32'h5555_AAAA; pc = 30'd0;
    expect_val(K_INSTR, 32'h0050_0093, "alias_pc0");
    cyc();
    quiet();
    mem_addr = 30'd5; pc = 30'h0000_1005;
    expect_val(K_RDATA, 32'h5555_AAAA, "alias_data");
    expect_val(K_INSTR, 32'h5555_AAAA, "alias_instr");
    cyc();

    mem_addr = A_SCRATCH; pc = A_TOHOST;
    expect_val(K_RDATA, 32'h0000_A5A5, "scratch_read");
    expect_val(K_INSTR, 32'h0, "mmio_pc_zero");
    cyc();
    mem_addr = A_OFF10;
    expect_val(K_RDATA, 32'h0, "mmio_unmapped");
    cyc();
    mem_addr = A_CYCLE;
    expect_val(K_RDATA, mcyc, "cycle_count");
    cyc();

    // CYCLE wrap
    expect_val(K_RDATA, mcyc, "cycle_preforce");
    force dut.cycle_d = 32'hFFFF_FFFF;
    cyc();
    release dut.cycle_d;
    mcyc = 32'hFFFF_FFFF;
    expect_val(K_RDATA, mcyc, "cycle_max");
    cyc();
    expect_val(K_RDATA, mcyc, "cycle_wrap");
    cyc();

    // TOHOST = 0 does not halt
    mem_write = 1'b1; mem_addr = A_TOHOST; mem_write_data = 32'h0;
    expect_val(K_RDATA, 32'h0, "tohost0_fwd");
    expect_val(K_TOHOST, 32'h0, "tohost0");
    expect_val(K_HALT, 32'h0, "tohost0_nohalt");
    cyc();

    // TOHOST = 1 halts
    mem_write_data = 32'h1;
    expect_val(K_RDATA, 32'h1, "tohost1_fwd");
    expect_val(K_TOHOST, 32'h1, "tohost1");
    expect_val(K_HALT, 32'h1, "halt_set");
    cyc();

    mem_addr = 30'd3; mem_write_data = 32'hBAD0_0BAD; pc = 30'd3;
    expect_val(K_INSTR, 32'h3333_3333, "halt_store_instr");
    expect_val(K_RDATA, 32'h3333_3333, "halt_store_data");
    cyc();
    quiet();
    mem_addr = A_CYCLE;
    expect_val(K_INSTR, 32'h3333_3333, "halt_mem3");
    expect_val(K_RDATA, mcyc, "cycle_frozen");
    expect_val(K_HALT, 32'h1, "halt_sticky");
    cyc();

    // loader still works while halted; CPU MMIO store ignored
    load_en = 1'b1; load_addr = 30'd3; load_data = 32'h4444_4444;
    mem_write = 1'b1; mem_addr = A_TOHOST; mem_write_data = 32'h5;
    expect_val(K_INSTR, 32'h4444_4444, "halt_loader");
    expect_val(K_RDATA, 32'h1, "halt_tohost_read");
    expect_val(K_TOHOST, 32'h1, "halt_tohost_kept");
    cyc();

    // mid-run reset keeps RAM
    quiet();
    rst = 1'b1;
    expect_val(K_INSTR, NOP, "rst2_instr");
    expect_val(K_RDATA, 32'h0, "rst2_rdata");
    expect_val(K_HALT, 32'h0, "rst2_halt");
    expect_val(K_TOHOST, 32'h0, "rst2_tohost");
    expect_val(K_COLL, 32'h0, "rst2_coll");
    cyc();
    rst = 1'b0; mem_addr = A_SCRATCH;
    expect_val(K_INSTR, 32'h4444_4444, "ram_survives");
    expect_val(K_RDATA, 32'h0, "scratch_cleared");
    cyc();
    mem_addr = A_CYCLE;
    expect_val(K_RDATA, mcyc, "cycle_restart");
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_mem_responder.md
RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 12, RAM depth in 32-bit words (2**DEPTH_LOG2).
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction value driven after reset.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc  input  30  CPU instruction word address.
REQ-006 mem_addr  input  30  CPU data word address.
REQ-007 mem_write  input  1  CPU data write strobe, one cycle per store.
REQ-008 mem_write_data  input  32  CPU store data.
REQ-009 load_en  input  1  bench/loader write strobe.
REQ-010 load_addr  input  30  loader word address.
REQ-011 load_data  input  32  loader write data.
REQ-012 instr  output  32  registered instruction-port read data.
REQ-013 mem_read_data  output  32  registered data-port read data.
REQ-014 halt  output  1  sticky, set on nonzero TOHOST write.
REQ-015 tohost  output  32  last value written to TOHOST.
REQ-016 collision  output  1  sticky, set when a CPU write is dropped because of a loader write.

Function
REQ-017 Address decode: MMIO when addr[29:8] is all ones, else RAM; RAM index is addr[DEPTH_LOG2-1:0] (upper bits alias/wrap).
REQ-018 MMIO map (offset addr[7:0]): 0x00 TOHOST (R/W), 0x01 CYCLE (RO), 0x02 SCRATCH (R/W); other offsets read 0 and ignore writes.
REQ-019 instr SHALL register mem[pc] every cycle: one-cycle latency, so the value is valid the cycle after pc changes.
REQ-020 mem_read_data SHALL register the data-port read of mem_addr every cycle: one-cycle latency, RAM or MMIO per REQ-017.
REQ-021 An MMIO pc SHALL return 32'h0 on instr.
REQ-022 The RAM has a single write port; priority is loader, then CPU.
REQ-023 Simultaneous load_en and mem_write to RAM: loader write takes effect, CPU write is dropped, and collision sets.
REQ-024 CPU write to MMIO SHALL NOT conflict with the loader; both take effect in the same cycle.
REQ-025 Write-first forwarding: a read address equal to the address being written that cycle SHALL return the new data on both ports.
REQ-026 CYCLE SHALL increment by 1 each non-reset cycle while halt=0, wrap 2^32-1 -> 0, and freeze once halt=1.
REQ-027 A CYCLE read SHALL return the counter value held during the cycle mem_addr was presented.
REQ-028 A TOHOST write SHALL update tohost; a nonzero value SHALL also set halt the following cycle.
REQ-029 While halt=1: CPU writes to RAM and MMIO are ignored; loader writes and reads continue.
REQ-030 A TOHOST write of 0 SHALL update tohost without setting halt.

Reset
REQ-031 On rst, instr SHALL be NOP_INSTR.
REQ-032 On rst, mem_read_data, tohost, CYCLE, and SCRATCH SHALL be 0.
REQ-033 On rst, halt and collision SHALL be 0.
REQ-034 RAM contents SHALL NOT be cleared by rst and SHALL survive a mid-run reset.
REQ-035 rst SHALL override any same-cycle write to MMIO registers; RAM writes in the reset cycle SHALL be ignored.

Verification
REQ-036 Load mem[0]=0x00500093 via loader, release rst, pc=0 -> instr=0x00500093 one cycle after; instr=0x00000013 during the reset cycle.
REQ-037 mem_write=1, mem_addr=5, data=0xDEADBEEF, and mem_addr=5 read the same cycle -> mem_read_data=0xDEADBEEF the next cycle; pc=5 the next cycle -> instr=0xDEADBEEF.
REQ-038 load_en with load_addr=7/0x11111111 and mem_write with mem_addr=9/0x22222222 in the same cycle -> mem[7]=0x11111111, mem[9] unchanged, collision=1.
REQ-039 Hold rst 1 cycle, then run 10 cycles and read CYCLE -> 10; preload CYCLE=0xFFFFFFFF via a force test -> next read 0.
REQ-040 Write TOHOST=0x1 -> tohost=1, halt=1, CYCLE frozen; a subsequent CPU store to mem[3] leaves mem[3] unchanged.
REQ-041 mem_addr=0x3FFF_1005 with DEPTH_LOG2=12 -> aliases RAM index 0x005; write SCRATCH=0xA5A5 then read -> 0xA5A5; read offset 0x10 -> 0.
